// File: rtl/io_bus_pkg.sv
// io_bus_pkg: shared types and constants for the dma_io bus arbiter.
// Holds bus widths, the master index type and the request record.
package io_bus_pkg;

   localparam int IO_AW = 14;
   localparam int IO_DW = 32;
   localparam int MAX_M = 8;

   typedef logic [2:0] m_idx_t;

   typedef struct packed {
      logic [IO_AW-1:0] adr;
      logic [IO_DW-1:0] data;
   } io_req_t;

   // Next master index after i, wrapping at n.
   function automatic m_idx_t idx_inc(m_idx_t i, int n);
      return (int'(i) == n - 1) ? m_idx_t'(0) : i + m_idx_t'(1);
   endfunction

endpackage

// File: rtl/io_bus_arbiter_rr_arbiter.sv
// rr_arbiter: picks one requester per cycle, searching from a pointer.
// Define IO_BUS_ARB_FIXED_PRIO_EN for highest-index-wins priority.
module rr_arbiter
   import io_bus_pkg::*;
#(
   parameter int NUM_M = 2
) (
   input  logic [NUM_M-1:0] req_i,
   input  m_idx_t           ptr_i,
   output logic [NUM_M-1:0] gnt_o,
   output m_idx_t           win_o,
   output logic             any_o
);

`ifdef IO_BUS_ARB_FIXED_PRIO_EN
   logic unused_ptr;
   assign unused_ptr = ^ptr_i;

   // Highest requesting index wins.
   always_comb begin
      gnt_o = '0;
      win_o = '0;
      any_o = 1'b0;
      for (int i = 0; i < NUM_M; i++) begin
         if (req_i[i]) begin
            gnt_o    = '0;
            gnt_o[i] = 1'b1;
            win_o    = m_idx_t'(i);
            any_o    = 1'b1;
         end
      end
   end
`else
   // First requester at or after the pointer wins.
   always_comb begin
      int j;
      gnt_o = '0;
      win_o = '0;
      any_o = 1'b0;
      j     = 0;
      for (int k = 0; k < NUM_M; k++) begin
         j = int'(ptr_i) + k;
         if (j >= NUM_M) begin
            j = j - NUM_M;
         end
         if (req_i[j] && !any_o) begin
            gnt_o[j] = 1'b1;
            win_o    = m_idx_t'(j);
            any_o    = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: registered N-master arbiter for the dma_io bus.
// Define IO_BUS_ARB_FIXED_PRIO_EN for fixed priority (no pointers).
module io_bus_arbiter
   import io_bus_pkg::*;
#(
   parameter int NUM_M  = 2,
   parameter int AW     = IO_AW,
   parameter int DW     = IO_DW,
   parameter int RD_LAT = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_M-1:0]    m_we,
   input  logic [NUM_M*AW-1:0] m_wadr,
   input  logic [NUM_M*DW-1:0] m_wdata,
   input  logic [NUM_M-1:0]    m_radr_en,
   input  logic [NUM_M*AW-1:0] m_radr,
   output logic [NUM_M-1:0]    m_wbusy,
   output logic [NUM_M-1:0]    m_rbusy,
   output logic [NUM_M-1:0]    m_rvalid,
   output logic [DW-1:0]       m_rdata,
   output logic                io_we,
   output logic [AW-1:0]       io_wadr,
   output logic [DW-1:0]       io_wdata,
   output logic                io_radr_en,
   output logic [AW-1:0]       io_radr,
   input  logic [DW-1:0]       io_rdata,
   output logic                proto_err
);

   io_req_t          wbuf_q [NUM_M];
   io_req_t          wbuf_d [NUM_M];
   io_req_t          wreq   [NUM_M];
   io_req_t          wsel;
   logic [NUM_M-1:0] wbuf_v_q, wbuf_v_d, wcand, wgnt;
   m_idx_t           wwin, wptr;
   logic             wany;

   logic [AW-1:0]    rbuf_q [NUM_M];
   logic [AW-1:0]    rbuf_d [NUM_M];
   logic [AW-1:0]    rreq   [NUM_M];
   logic [AW-1:0]    rsel;
   logic [NUM_M-1:0] rbuf_v_q, rbuf_v_d, rcand, rgnt;
   logic [NUM_M-1:0] rout_q, rout_d, rbusy;
   m_idx_t           rwin, rptr;
   logic             rany;

   logic [RD_LAT:0]  own_v_q;
   m_idx_t           own_id_q [RD_LAT+1];

   logic             io_we_q, io_ren_q, perr_q, perr_d;
   logic [AW-1:0]    io_wadr_q, io_radr_q;
   logic [DW-1:0]    io_wdata_q, m_rdata_q;
   logic [NUM_M-1:0] m_rvalid_q;

   assign rbusy = rbuf_v_q | rout_q;
   assign wcand = wbuf_v_q | m_we;
   assign rcand = rbuf_v_q | (m_radr_en & ~rbusy);

   // Present each master's request; a held entry outranks a fresh strobe.
   always_comb begin
      for (int i = 0; i < NUM_M; i++) begin
         wreq[i] = wbuf_v_q[i] ? wbuf_q[i]
                 : io_req_t'({m_wadr[i*AW +: AW], m_wdata[i*DW +: DW]});
         rreq[i] = rbuf_v_q[i] ? rbuf_q[i] : m_radr[i*AW +: AW];
      end
   end

   rr_arbiter #(.NUM_M(NUM_M)) u_warb (
      .req_i (wcand),
      .ptr_i (wptr),
      .gnt_o (wgnt),
      .win_o (wwin),
      .any_o (wany)
   );

   rr_arbiter #(.NUM_M(NUM_M)) u_rarb (
      .req_i (rcand),
      .ptr_i (rptr),
      .gnt_o (rgnt),
      .win_o (rwin),
      .any_o (rany)
   );

   // Winner selection and holding-buffer next state for both paths.
   always_comb begin
      wsel     = '0;
      rsel     = '0;
      wbuf_v_d = wbuf_v_q;
      rbuf_v_d = rbuf_v_q;
      wbuf_d   = wbuf_q;
      rbuf_d   = rbuf_q;
      for (int i = 0; i < NUM_M; i++) begin
         if (wgnt[i]) begin
            wsel        = wreq[i];
            wbuf_v_d[i] = 1'b0;
         end else if (m_we[i] && !wbuf_v_q[i]) begin
            wbuf_v_d[i] = 1'b1;
            wbuf_d[i]   = wreq[i];
         end
         if (rgnt[i]) begin
            rsel        = rreq[i];
            rbuf_v_d[i] = 1'b0;
         end else if (m_radr_en[i] && !rbusy[i]) begin
            rbuf_v_d[i] = 1'b1;
            rbuf_d[i]   = rreq[i];
         end
      end
   end

   assign rout_d = (rout_q & ~m_rvalid_q) | rgnt;
   assign perr_d = perr_q | (|(m_we & wbuf_v_q)) | (|(m_radr_en & rbusy));

`ifdef IO_BUS_ARB_FIXED_PRIO_EN
   logic unused_win;
   assign unused_win = ^wwin;
   assign wptr = '0;
   assign rptr = '0;
`else
   m_idx_t wptr_q, wptr_d, rptr_q, rptr_d;
   assign wptr_d = wany ? idx_inc(wwin, NUM_M) : wptr_q;
   assign rptr_d = rany ? idx_inc(rwin, NUM_M) : rptr_q;
   assign wptr   = wptr_q;
   assign rptr   = rptr_q;

   // Round-robin pointers step past each winner.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end
`endif

   // Holding buffers, outstanding-read flags and the sticky error.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wbuf_v_q <= '0;
         rbuf_v_q <= '0;
         rout_q   <= '0;
         perr_q   <= 1'b0;
         for (int i = 0; i < NUM_M; i++) begin
            wbuf_q[i] <= '0;
            rbuf_q[i] <= '0;
         end
      end else begin
         wbuf_v_q <= wbuf_v_d;
         rbuf_v_q <= rbuf_v_d;
         rout_q   <= rout_d;
         perr_q   <= perr_d;
         wbuf_q   <= wbuf_d;
         rbuf_q   <= rbuf_d;
      end
   end

   // Bus-side registers and read-data return routing.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         io_we_q    <= 1'b0;
         io_wadr_q  <= '0;
         io_wdata_q <= '0;
         io_ren_q   <= 1'b0;
         io_radr_q  <= '0;
         own_v_q    <= '0;
         m_rvalid_q <= '0;
         m_rdata_q  <= '0;
         for (int k = 0; k <= RD_LAT; k++) begin
            own_id_q[k] <= '0;
         end
      end else begin
         io_we_q  <= wany;
         io_ren_q <= rany;
         if (wany) begin
            io_wadr_q  <= wsel.adr;
            io_wdata_q <= wsel.data;
         end
         if (rany) begin
            io_radr_q <= rsel;
         end
         own_v_q     <= {own_v_q[RD_LAT-1:0], rany};
         own_id_q[0] <= rwin;
         for (int k = 1; k <= RD_LAT; k++) begin
            own_id_q[k] <= own_id_q[k-1];
         end
         for (int i = 0; i < NUM_M; i++) begin
            m_rvalid_q[i] <= own_v_q[RD_LAT]
                          && (own_id_q[RD_LAT] == m_idx_t'(i));
         end
         if (own_v_q[RD_LAT]) begin
            m_rdata_q <= io_rdata;
         end
      end
   end

   assign m_wbusy    = wbuf_v_q;
   assign m_rbusy    = rbusy;
   assign m_rvalid   = m_rvalid_q;
   assign m_rdata    = m_rdata_q;
   assign io_we      = io_we_q;
   assign io_wadr    = io_wadr_q;
   assign io_wdata   = io_wdata_q;
   assign io_radr_en = io_ren_q;
   assign io_radr    = io_radr_q;
   assign proto_err  = perr_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb_io_bus_arbiter: directed table, corner sequences and a random
// run against a transaction-level model of the arbiter.
module tb_io_bus_arbiter;

   localparam int M  = 2;
   localparam int AW = 14;
   localparam int DW = 32;
   localparam int RL = 2;

`ifdef IO_BUS_ARB_FIXED_PRIO_EN
   localparam logic [1:0] COLL_BUSY = 2'b01;
`else
   localparam logic [1:0] COLL_BUSY = 2'b10;
`endif

   logic            clk, rst_n;
   logic [M-1:0]    m_we, m_radr_en, m_wbusy, m_rbusy, m_rvalid;
   logic [M*AW-1:0] m_wadr, m_radr;
   logic [M*DW-1:0] m_wdata;
   logic [DW-1:0]   m_rdata, io_wdata, io_rdata;
   logic            io_we, io_radr_en, proto_err;
   logic [AW-1:0]   io_wadr, io_radr;

   int n_tests = 0;
   int n_fail  = 0;

   io_bus_arbiter #(.NUM_M(M), .AW(AW), .DW(DW), .RD_LAT(RL)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .m_we       (m_we),
      .m_wadr     (m_wadr),
      .m_wdata    (m_wdata),
      .m_radr_en  (m_radr_en),
      .m_radr     (m_radr),
      .m_wbusy    (m_wbusy),
      .m_rbusy    (m_rbusy),
      .m_rvalid   (m_rvalid),
      .m_rdata    (m_rdata),
      .io_we      (io_we),
      .io_wadr    (io_wadr),
      .io_wdata   (io_wdata),
      .io_radr_en (io_radr_en),
      .io_radr    (io_radr),
      .io_rdata   (io_rdata),
      .proto_err  (proto_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] rdfun(logic [13:0] a);
      return 32'hdeadbeef ^ {18'h0, a ^ 14'h0100};
   endfunction

   // Peripheral chain: data for a read appears RL cycles after its strobe.
   logic          pe_v [RL] = '{default: 1'b0};
   logic [AW-1:0] pe_a [RL] = '{default: '0};
   always @(negedge clk) begin
      pe_v[0] <= io_radr_en;
      pe_a[0] <= io_radr;
      for (int k = 1; k < RL; k++) begin
         pe_v[k] <= pe_v[k-1];
         pe_a[k] <= pe_a[k-1];
      end
      io_rdata <= pe_v[RL-1] ? rdfun(pe_a[RL-1]) : $urandom;
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      m_we = '0;
      m_radr_en = '0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic int pick(logic [M-1:0] c, int p);
`ifdef IO_BUS_ARB_FIXED_PRIO_EN
      for (int j = M - 1; j >= 0; j--) if (c[j]) return j;
      if (p < 0) return -1;
`else
      for (int k = 0; k < M; k++) if (c[(p + k) % M]) return (p + k) % M;
`endif
      return -1;
   endfunction

   typedef struct {
      logic [1:0]  we;
      logic [13:0] a0, a1;
      logic [31:0] d0, d1;
      logic        e_we;
      logic [13:0] e_adr;
      logic [31:0] e_dat;
      logic [1:0]  e_busy;
      logic        e_perr;
   } vec_t;

   vec_t tbl [8];

   // Random-run model state.
   int            ptr_w, ptr_r, cyc;
   bit            mw_v [M];
   logic [AW-1:0] mw_a [M];
   logic [DW-1:0] mw_d [M];
   bit            mr_v [M];
   logic [AW-1:0] mr_a [M];
   int            rd_until [M];
   logic [DW-1:0] rd_dat [M];
   logic          e_we, e_re, e_perr;
   logic [AW-1:0] e_wa, e_ra;
   logic [DW-1:0] e_wd;

   task automatic run_random(int n);
      logic [M-1:0]  bw, br, ev, we, re, wc, rc;
      logic [AW-1:0] fa [M];
      logic [AW-1:0] ra [M];
      logic [DW-1:0] fd [M];
      int            w, r;
      ptr_w = 0; ptr_r = 0; cyc = 0;
      e_we = 0; e_re = 0; e_perr = 0; e_wa = '0; e_ra = '0; e_wd = '0;
      for (int i = 0; i < M; i++) begin
         mw_v[i] = 0; mr_v[i] = 0; rd_until[i] = -1;
      end
      for (int t = 0; t < n; t++) begin
         for (int i = 0; i < M; i++) begin
            bw[i] = mw_v[i];
            br[i] = mr_v[i] || (cyc <= rd_until[i]);
            ev[i] = (rd_until[i] == cyc);
         end
         chk($sformatf("rnd%0d io_we", t), io_we, e_we);
         chk($sformatf("rnd%0d io_wadr", t), io_wadr, e_wa);
         chk($sformatf("rnd%0d io_wdata", t), io_wdata, e_wd);
         chk($sformatf("rnd%0d io_radr_en", t), io_radr_en, e_re);
         chk($sformatf("rnd%0d io_radr", t), io_radr, e_ra);
         chk($sformatf("rnd%0d m_wbusy", t), m_wbusy, bw);
         chk($sformatf("rnd%0d m_rbusy", t), m_rbusy, br);
         chk($sformatf("rnd%0d m_rvalid", t), m_rvalid, ev);
         chk($sformatf("rnd%0d proto_err", t), proto_err, e_perr);
         for (int i = 0; i < M; i++)
            if (ev[i]) chk($sformatf("rnd%0d m_rdata", t), m_rdata, rd_dat[i]);
         for (int i = 0; i < M; i++) begin
            we[i] = ($urandom_range(0, 99) < 45);
            re[i] = ($urandom_range(0, 99) < 45);
            if (bw[i] && !(t >= n / 2 && $urandom_range(0, 99) < 5)) we[i] = 0;
            if (br[i] && !(t >= n / 2 && $urandom_range(0, 99) < 5)) re[i] = 0;
            fa[i] = AW'($urandom);
            fd[i] = $urandom;
            ra[i] = AW'($urandom);
            m_wadr[i*AW +: AW]  = fa[i];
            m_wdata[i*DW +: DW] = fd[i];
            m_radr[i*AW +: AW]  = ra[i];
         end
         m_we = we;
         m_radr_en = re;
         if ((we & bw) != 0 || (re & br) != 0) e_perr = 1;
         for (int i = 0; i < M; i++) begin
            wc[i] = mw_v[i] || we[i];
            rc[i] = mr_v[i] || (re[i] && !br[i]);
         end
         w = pick(wc, ptr_w);
         e_we = (w >= 0);
         if (w >= 0) begin
            e_wa = mw_v[w] ? mw_a[w] : fa[w];
            e_wd = mw_v[w] ? mw_d[w] : fd[w];
            mw_v[w] = 0;
            ptr_w = (w + 1) % M;
         end
         r = pick(rc, ptr_r);
         e_re = (r >= 0);
         if (r >= 0) begin
            e_ra = mr_v[r] ? mr_a[r] : ra[r];
            rd_until[r] = cyc + RL + 2;
            rd_dat[r] = rdfun(e_ra);
            mr_v[r] = 0;
            ptr_r = (r + 1) % M;
         end
         for (int i = 0; i < M; i++) begin
            if (i != w && we[i] && !bw[i]) begin
               mw_v[i] = 1; mw_a[i] = fa[i]; mw_d[i] = fd[i];
            end
            if (i != r && re[i] && !br[i]) begin
               mr_v[i] = 1; mr_a[i] = ra[i];
            end
         end
         @(negedge clk);
         cyc++;
      end
      m_we = '0;
      m_radr_en = '0;
   endtask

   initial begin
      rst_n = 1'b0;
      m_we = '0; m_radr_en = '0;
      m_wadr = '0; m_wdata = '0; m_radr = '0;

      tbl[0] = '{2'b01, 14'h40, 14'h0, 32'h12345678, 32'h0,
                 1'b1, 14'h40, 32'h12345678, 2'b00, 1'b0};
      tbl[1] = '{2'b10, 14'h0, 14'h41, 32'h0, 32'h11110001,
                 1'b1, 14'h41, 32'h11110001, 2'b00, 1'b0};
`ifdef IO_BUS_ARB_FIXED_PRIO_EN
      tbl[2] = '{2'b11, 14'h50, 14'h51, 32'ha0a0a0a0, 32'hb1b1b1b1,
                 1'b1, 14'h51, 32'hb1b1b1b1, 2'b01, 1'b0};
      tbl[3] = '{2'b00, 14'h0, 14'h0, 32'h0, 32'h0,
                 1'b1, 14'h50, 32'ha0a0a0a0, 2'b00, 1'b0};
      tbl[4] = '{2'b00, 14'h0, 14'h0, 32'h0, 32'h0,
                 1'b0, 14'h50, 32'ha0a0a0a0, 2'b00, 1'b0};
      tbl[5] = '{2'b11, 14'h60, 14'h61, 32'hc0c0c0c0, 32'hd1d1d1d1,
                 1'b1, 14'h61, 32'hd1d1d1d1, 2'b01, 1'b0};
      tbl[6] = '{2'b01, 14'h77, 14'h0, 32'heeeeeeee, 32'h0,
                 1'b1, 14'h60, 32'hc0c0c0c0, 2'b00, 1'b1};
      tbl[7] = '{2'b00, 14'h0, 14'h0, 32'h0, 32'h0,
                 1'b0, 14'h60, 32'hc0c0c0c0, 2'b00, 1'b1};
`else
      tbl[2] = '{2'b11, 14'h50, 14'h51, 32'ha0a0a0a0, 32'hb1b1b1b1,
                 1'b1, 14'h50, 32'ha0a0a0a0, 2'b10, 1'b0};
      tbl[3] = '{2'b00, 14'h0, 14'h0, 32'h0, 32'h0,
                 1'b1, 14'h51, 32'hb1b1b1b1, 2'b00, 1'b0};
      tbl[4] = '{2'b00, 14'h0, 14'h0, 32'h0, 32'h0,
                 1'b0, 14'h51, 32'hb1b1b1b1, 2'b00, 1'b0};
      tbl[5] = '{2'b11, 14'h60, 14'h61, 32'hc0c0c0c0, 32'hd1d1d1d1,
                 1'b1, 14'h60, 32'hc0c0c0c0, 2'b10, 1'b0};
      tbl[6] = '{2'b10, 14'h0, 14'h77, 32'h0, 32'heeeeeeee,
                 1'b1, 14'h61, 32'hd1d1d1d1, 2'b00, 1'b1};
      tbl[7] = '{2'b00, 14'h0, 14'h0, 32'h0, 32'h0,
                 1'b0, 14'h61, 32'hd1d1d1d1, 2'b00, 1'b1};
`endif

      // Reset state.
      @(negedge clk);
      @(negedge clk);
      chk("rst io_we", io_we, 0);
      chk("rst io_wadr", io_wadr, 0);
      chk("rst io_radr_en", io_radr_en, 0);
      chk("rst m_wbusy", m_wbusy, 0);
      chk("rst m_rbusy", m_rbusy, 0);
      chk("rst m_rvalid", m_rvalid, 0);
      chk("rst m_rdata", m_rdata, 0);
      chk("rst proto_err", proto_err, 0);
      rst_n = 1'b1;

      // Directed write table.
      for (int r = 0; r < 8; r++) begin
         m_we    = tbl[r].we;
         m_wadr  = {tbl[r].a1, tbl[r].a0};
         m_wdata = {tbl[r].d1, tbl[r].d0};
         @(negedge clk);
         chk($sformatf("tbl%0d io_we", r), io_we, tbl[r].e_we);
         chk($sformatf("tbl%0d io_wadr", r), io_wadr, tbl[r].e_adr);
         chk($sformatf("tbl%0d io_wdata", r), io_wdata, tbl[r].e_dat);
         chk($sformatf("tbl%0d m_wbusy", r), m_wbusy, tbl[r].e_busy);
         chk($sformatf("tbl%0d proto_err", r), proto_err, tbl[r].e_perr);
      end
      m_we = '0;

      // Read return with RD_LAT=2 from master 1.
      do_reset();
      chk("rd busy before", m_rbusy, 0);
      m_radr_en = 2'b10;
      m_radr = {14'h100, 14'h0};
      for (int j = 1; j <= 5; j++) begin
         @(negedge clk);
         m_radr_en = '0;
         chk($sformatf("rd N+%0d io_radr_en", j), io_radr_en, j == 1);
         chk($sformatf("rd N+%0d m_rbusy", j), m_rbusy,
             (j <= 4) ? 2'b10 : 2'b00);
         chk($sformatf("rd N+%0d m_rvalid", j), m_rvalid,
             (j == 4) ? 2'b10 : 2'b00);
         if (j == 1) chk("rd io_radr", io_radr, 14'h100);
         if (j == 4) chk("rd m_rdata", m_rdata, 32'hdeadbeef);
      end

      // Reset while a read is in flight.
      m_radr_en = 2'b01;
      m_radr = {14'h0, 14'h22};
      @(negedge clk);
      chk("mid io_radr_en", io_radr_en, 1);
      chk("mid io_radr", io_radr, 14'h22);
      m_radr_en = 2'b01;
      m_we = 2'b11;
      @(negedge clk);
      m_we = '0;
      m_radr_en = '0;
      chk("mid m_wbusy", m_wbusy, COLL_BUSY);
      chk("mid proto_err", proto_err, 1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int j = 0; j < 5; j++) begin
         chk($sformatf("mid+%0d m_rvalid", j), m_rvalid, 0);
         chk($sformatf("mid+%0d busy", j), {m_wbusy, m_rbusy}, 0);
         chk($sformatf("mid+%0d proto_err", j), proto_err, 0);
         @(negedge clk);
      end

      // Fairness: both masters write whenever not busy.
      do_reset();
      for (int c = 0; c < 20; c++) begin
         for (int i = 0; i < M; i++) begin
            m_we[i] = !m_wbusy[i];
            m_wadr[i*AW +: AW] = AW'(i * 256 + c);
         end
         @(negedge clk);
`ifdef IO_BUS_ARB_FIXED_PRIO_EN
         chk($sformatf("fair%0d", c), {io_we, io_wadr[8]}, 2'b11);
`else
         chk($sformatf("fair%0d", c), {io_we, io_wadr[8]},
             {1'b1, c[0]});
`endif
      end
      m_we = '0;

      // Random traffic against the model.
      do_reset();
      run_random(1500);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/io_bus_arbiter.md
Name: io_bus_arbiter

Overview:
- Parametrised N-master arbiter for the shared dma_io peripheral bus (word address [15:2], 32-bit data).
- Replaces the fixed two-master combinational mux with registered, fair arbitration.
- Adds per-master write/read holding buffers, read-data return routing and a protocol-error flag.
- Sits between bus masters (CPU core, UART debug engine, future DMA) and the daisy-chained io peripherals.

Parameters:
- NUM_M, 2: number of masters (2..8).
- AW, 14: word address width (bus address bits [15:2]).
- DW, 32: data width.
- RD_LAT, 1: cycles from io_radr_en on the bus to valid io_rdata (1..4).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- m_we  in  NUM_M  per-master write strobe, one-cycle pulse.
- m_wadr  in  NUM_M*AW  write word address; master i in slice [i*AW +: AW].
- m_wdata  in  NUM_M*DW  write data, sliced the same way.
- m_radr_en  in  NUM_M  per-master read strobe, one-cycle pulse.
- m_radr  in  NUM_M*AW  read word address.
- m_wbusy  out  NUM_M  master's write buffer full; master must not issue m_we.
- m_rbusy  out  NUM_M  master's read buffer full or read outstanding; master must not issue m_radr_en.
- m_rvalid  out  NUM_M  one-cycle pulse: m_rdata belongs to master i.
- m_rdata  out  DW  returned read data, shared by all masters.
- io_we  out  1  bus write strobe, registered.
- io_wadr  out  AW  bus write address, registered.
- io_wdata  out  DW  bus write data, registered.
- io_radr_en  out  1  bus read strobe, registered.
- io_radr  out  AW  bus read address, registered.
- io_rdata  in  DW  read data from the end of the peripheral chain.
- proto_err  out  1  sticky; set on any request issued while that master's busy flag is high.

Behaviour:
- Reset (rst_n low at a clk edge): all outputs 0, buffers empty, round-robin pointers 0, read-owner pipeline cleared. Any in-flight read is dropped and no m_rvalid is issued for it.
- Write and read paths are independent. Each has its own arbiter, pointer and per-master one-entry buffer.
- Write candidate for master i: buffer i full, or m_we[i] high with buffer i empty. A full buffer always wins over a fresh strobe from the same master.
- Cycle N: the arbiter picks one winner. Cycle N+1: io_we=1, io_wadr/io_wdata hold the winner's values. Latency is exactly 1 cycle when uncontended.
- A losing fresh write is captured into its buffer in cycle N. m_wbusy[i]=1 from N+1 until the buffered entry is granted. It clears in the cycle after the grant.
- At most one io_we per cycle. io_we stays low when there are no candidates; io_wadr/io_wdata keep their last values.
- The read path is identical for arbitration and buffering. m_rbusy[i] additionally stays high from acceptance until m_rvalid[i] fires, so each master has at most one outstanding read.
- Read return: winner id enters a RD_LAT-deep owner shift register alongside io_radr_en. RD_LAT cycles after io_radr_en=1, io_rdata is registered into m_rdata and m_rvalid[owner] pulses. Total latency from an uncontended m_radr_en to m_rvalid is RD_LAT+2.
- Back-to-back reads from different masters pipeline at one per cycle.
- Round-robin: after a grant the pointer moves to winner+1 mod NUM_M. The search starts at the pointer. With no grant the pointer holds.
- Request while busy: the request is dropped, the buffer is unchanged and proto_err is set. proto_err clears only on reset.
- The same master may issue a write and a read in the same cycle; both are serviced independently.

Optional Feature:
- IO_BUS_ARB_FIXED_PRIO_EN defined: both arbiters use fixed priority, highest index wins, and the pointers are removed.
- Undefined: round-robin as above.
- Buffering, latency and error behaviour are identical in both builds.

Decomposition:
- Shared package io_bus_pkg holds:
  - IO_AW=14 and IO_DW=32 constants.
  - Master-index typedef sized for 8 masters.
  - io_req_t struct {adr, data}.
- Sub-module rr_arbiter:
  - NUM_M request vector and pointer in; one-hot grant and encoded winner out.
  - Implements the fixed-priority variant under the macro.
  - Instantiated twice, once per path.

Test Plan:
- Single write: NUM_M=2, m_we[0] with adr 0x0040, data 0x12345678 -> next cycle io_we=1, io_wadr=0x0040, io_wdata=0x12345678; m_wbusy stays 0.
- Write collision: m_we[0] and m_we[1] in the same cycle, pointer 0 -> master 0 on the bus at N+1, master 1 at N+2; m_wbusy[1]=1 only during N+1.
- Fairness: both masters write every cycle when not busy, for 20 cycles -> grants alternate 0,1,0,1; with IO_BUS_ARB_FIXED_PRIO_EN, master 1 always wins when both request.
- Read return, RD_LAT=2: m_radr_en[1] with adr 0x0100, peripheral model drives 0xdeadbeef -> io_radr_en at N+1, m_rvalid[1]=1 with m_rdata=0xdeadbeef at N+4; m_rbusy[1] high N+1..N+4.
- Protocol error: m_we[1] asserted while m_wbusy[1]=1 -> request dropped, buffered entry unchanged, proto_err=1 until reset.
- Reset mid-read: rst_n low 1 cycle after io_radr_en -> no m_rvalid pulse, all busy flags 0, proto_err 0.
